// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings
// and the fixed instruction size used to advance the fetch PC.
package fetch_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        WAIT   = 1'b1
    } fetch_state_t;

    localparam int INSTRUCTION_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries for decode.
// Push and pop may coincide, including when full (count unchanged).
// Flush and reset both clear the pointers, the count and every storage slot.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int DEPTH_BITWIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    empty,
    output logic                    full,
    output logic [DEPTH_BITWIDTH:0] count
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;

    logic [WIDTH-1:0]          storage [DEPTH];
    logic [DEPTH_BITWIDTH-1:0] rd_ptr;
    logic [DEPTH_BITWIDTH-1:0] wr_ptr;
    logic                      do_push;
    logic                      do_pop;

    // A pop frees the head slot in the same cycle, so a full queue can accept a push alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; flush empties everything just like reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Count reaches exactly DEPTH only when full, which is the only value with the top bit set
    assign head_data = storage[rd_ptr];
    assign empty     = (count == '0);
    assign full      = count[DEPTH_BITWIDTH];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage in front of cache read port B. Presents the fetch
// PC to the cache for one settle cycle, then waits for a clean read (ready,
// not busy, room in the queue) and captures {pc, instruction} into the
// prefetch FIFO drained by decode. A redirect reloads the PC, flushes the
// queue and discards any capture in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                          ADDRESS_BITWIDTH     = 32,
    parameter int                          INSTRUCTION_BITWIDTH = 32,
    parameter int                          QUEUE_DEPTH_BITWIDTH = 2,
    parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC             = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            redirect,
    input  logic [ADDRESS_BITWIDTH-1:0]     redirect_pc,
    output logic [ADDRESS_BITWIDTH-1:0]     c_addr,
    input  logic [INSTRUCTION_BITWIDTH-1:0] c_dout,
    input  logic                            c_rdy,
    input  logic                            c_bsy,
    output logic                            ins_valid,
    output logic [INSTRUCTION_BITWIDTH-1:0] ins,
    output logic [ADDRESS_BITWIDTH-1:0]     ins_pc,
    input  logic                            ins_ready
);

    localparam int ENTRY_WIDTH = ADDRESS_BITWIDTH + INSTRUCTION_BITWIDTH;

    fetch_state_t                      state;
    fetch_state_t                      next_state;
    logic [ADDRESS_BITWIDTH-1:0]       fetch_pc;
    logic                              capture;
    logic                              pop;
    logic                              fifo_push;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic [QUEUE_DEPTH_BITWIDTH:0]     fifo_count;
    logic [ENTRY_WIDTH-1:0]            head_data;

    assign pop       = ins_ready && !fifo_empty;
    assign fifo_push = capture && !redirect;

    // State register; a redirect always restarts from the settle cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SETTLE;
        end else if (redirect) begin
            state <= SETTLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: settle lasts one cycle, wait ends only on a capture
    always_comb begin
        next_state = state;
        case (state)
            SETTLE:  next_state = WAIT;
            WAIT:    next_state = capture ? SETTLE : WAIT;
            default: next_state = SETTLE;
        endcase
    end

    // Capture decision: clean cache read and a free slot (a concurrent pop frees one)
    always_comb begin
        capture = 1'b0;
        if (state == WAIT) begin
            capture = c_rdy && !c_bsy && (!fifo_full || pop);
        end
    end

    // Fetch PC: redirect wins and drops the low address bits; otherwise advance on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[ADDRESS_BITWIDTH-1:2], 2'b00};
        end else if (capture) begin
            fetch_pc <= fetch_pc + ADDRESS_BITWIDTH'(INSTRUCTION_BYTES);
        end
    end

    fetch_fifo #(
        .WIDTH          (ENTRY_WIDTH),
        .DEPTH_BITWIDTH (QUEUE_DEPTH_BITWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({fetch_pc, c_dout}),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign c_addr        = fetch_pc;
    assign ins_valid     = (fifo_count != '0);
    assign {ins_pc, ins} = head_data;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue with a behavioural cache: lines of 16 bytes that
// miss for a fixed number of cycles before becoming resident, or a stub
// mode that always hits. Expected {pc, instruction} pairs are queued when a
// fetch sequence is started and compared whenever decode takes the head.
module tb_fetch_queue;

    localparam int FILL_CYCLES = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] c_addr;
    logic [31:0] c_dout;
    logic        c_rdy;
    logic        c_bsy;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    logic        stub_mode;
    logic        cache_flush;
    logic [255:0] resident;
    int          fill_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          pops_seen = 0;
    int          pop_cycle_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDRESS_BITWIDTH     (32),
        .INSTRUCTION_BITWIDTH (32),
        .QUEUE_DEPTH_BITWIDTH (2),
        .RESET_PC             (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .c_addr      (c_addr),
        .c_dout      (c_dout),
        .c_rdy       (c_rdy),
        .c_bsy       (c_bsy),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready)
    );

    // Instruction memory contents seen through the cache
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'hB7C6_A980;
            32'h0000_0004: mem_word = 32'h3F5A_2E14;
            32'h0000_0008: mem_word = 32'hAB4C_3E6F;
            32'h0000_0040: mem_word = 32'h4E5F_6A7B;
            default:       mem_word = {a[15:0] ^ 16'h5A3C, ~a[15:0]};
        endcase
    endfunction

    // Cache read port: data for the presented address, busy while its line is not resident
    always_comb begin
        if (stub_mode) begin
            c_rdy = 1'b1;
            c_bsy = 1'b0;
        end else begin
            c_rdy = resident[c_addr[11:4]];
            c_bsy = !resident[c_addr[11:4]];
        end
        c_dout = mem_word(c_addr);
    end

    // Line fill: a missing line becomes resident after FILL_CYCLES clocks
    always @(posedge clk) begin
        if (cache_flush) begin
            resident <= '0;
            fill_cnt <= 0;
        end else if (!stub_mode && !resident[c_addr[11:4]]) begin
            if (fill_cnt == FILL_CYCLES - 1) begin
                resident[c_addr[11:4]] <= 1'b1;
                fill_cnt               <= 0;
            end else begin
                fill_cnt <= fill_cnt + 1;
            end
        end else begin
            fill_cnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        ins_ready   = ready;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    // Start a new expected fetch stream at the given address
    task automatic load_expect(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back({pc, mem_word(pc)});
            pc = pc + 32'd4;
        end
    endtask

    // One clock: check any handshake at the falling edge, then step past the rising edge
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("pop_without_expectation", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pop_entry", {ins_pc, ins}, e);
            end
            pop_cycle_q.push_back(cycle);
            pops_seen++;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic wait_pops(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (pops_seen < target && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(pops_seen >= target), 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pops_seen = 0;
        pop_cycle_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        seen;
        logic [31:0] addr_mid;
        logic [31:0] prev;
        int          k;

        rst         = 1'b1;
        stub_mode   = 1'b0;
        cache_flush = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        tick();
        tick();
        cache_flush = 1'b0;

        $display("[TB] reset values");
        checkOutput("reset_c_addr", 64'(c_addr), 64'h0);
        checkOutput("reset_ins_valid", 64'(ins_valid), 64'h0);
        checkOutput("reset_ins", 64'(ins), 64'h0);
        checkOutput("reset_ins_pc", 64'(ins_pc), 64'h0);

        $display("[TB] first fetches through a line fill");
        load_expect(32'h0);
        ins_ready = 1'b1;
        rst       = 1'b0;
        seen      = 1'b0;
        k         = 0;
        while (c_bsy && k < 20) begin
            if (ins_valid) seen = 1'b1;
            tick();
            k++;
        end
        checkOutput("valid_during_fill", 64'(seen), 64'h0);
        wait_pops("first_three_pops", 3, 40);
        if (pop_cycle_q.size() >= 3) begin
            checkOutput("pop_spacing_1", 64'(pop_cycle_q[1] - pop_cycle_q[0]), 64'd2);
            checkOutput("pop_spacing_2", 64'(pop_cycle_q[2] - pop_cycle_q[1]), 64'd2);
        end
        wait_pops("warm_second_line", 8, 80);

        $display("[TB] queue full, decode stalled");
        ins_ready = 1'b0;
        load_expect(32'h0);
        pulse_reset();
        addr_mid = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) addr_mid = c_addr;
        end
        checkOutput("full_c_addr_mid", 64'(addr_mid), 64'h10);
        checkOutput("full_c_addr_end", 64'(c_addr), 64'h10);
        checkOutput("full_ins_valid", 64'(ins_valid), 64'h1);
        checkOutput("full_head_pc", 64'(ins_pc), 64'h0);
        ins_ready = 1'b1;
        tick();
        checkOutput("pop_with_capture_pops", 64'(pops_seen), 64'd1);
        checkOutput("pop_with_capture_c_addr", 64'(c_addr), 64'h14);
        wait_pops("drain_after_full", 5, 40);

        $display("[TB] redirect with three queued entries");
        ins_ready = 1'b0;
        pulse_reset();
        k = 0;
        while (c_addr != 32'hC && k < 20) begin
            tick();
            k++;
        end
        checkOutput("reach_three_entries", 64'(c_addr), 64'hC);
        applyStimulus(1'b0, 1'b1, 32'h42);
        cache_flush = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        cache_flush = 1'b0;
        checkOutput("redirect_flush_valid", 64'(ins_valid), 64'h0);
        checkOutput("redirect_c_addr", 64'(c_addr), 64'h40);
        load_expect(32'h40);
        pops_seen = 0;
        ins_ready = 1'b1;
        wait_pops("redirect_target_pop", 1, 40);

        $display("[TB] redirect coinciding with capture and pop");
        stub_mode = 1'b1;
        ins_ready = 1'b0;
        load_expect(32'h0);
        pulse_reset();
        for (int i = 0; i < 4; i++) tick();
        prev = c_addr;
        k = 0;
        while (c_addr == prev && k < 4) begin
            tick();
            k++;
        end
        checkOutput("sync_to_settle", 64'(c_addr != prev), 64'h1);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h100);
        pops_seen = 0;
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redirect_pop_taken", 64'(pops_seen), 64'd1);
        checkOutput("collide_flush_valid", 64'(ins_valid), 64'h0);
        checkOutput("collide_c_addr", 64'(c_addr), 64'h100);
        load_expect(32'h100);
        pops_seen = 0;
        wait_pops("collide_new_stream", 2, 20);

        $display("[TB] fetch PC wrap");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        load_expect(32'hFFFF_FFFC);
        pops_seen = 0;
        wait_pops("wrap_stream", 3, 20);

        $display("[TB] asynchronous reset during a miss");
        ins_ready = 1'b0;
        load_expect(32'h0);
        pulse_reset();
        for (int i = 0; i < 6; i++) tick();
        checkOutput("pre_reset_valid", 64'(ins_valid), 64'h1);
        stub_mode   = 1'b0;
        cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_c_addr", 64'(c_addr), 64'h0);
        checkOutput("async_reset_valid", 64'(ins_valid), 64'h0);
        checkOutput("async_reset_ins", 64'(ins), 64'h0);
        checkOutput("async_reset_ins_pc", 64'(ins_pc), 64'h0);
        tick();
        rst       = 1'b0;
        pops_seen = 0;
        ins_ready = 1'b1;
        checkOutput("refetch_reset_pc", 64'(c_addr), 64'h0);
        wait_pops("refetch_after_reset", 1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
